// File: rtl/cm_loop_ctrl_if.sv
// Tuple stream between cm_loop_ctrl and its consumer: one index tuple per
// accepted valid/ready beat, with row/frame position flags.
interface cm_loop_ctrl_if #(
    parameter int C_WIDTH = 8
);
    logic               O_valid;
    logic               I_ready;
    logic [C_WIDTH-1:0] O_idx0;
    logic [C_WIDTH-1:0] O_idx1;
    logic [C_WIDTH-1:0] O_idx2;
    logic               O_first;
    logic               O_row_end;
    logic               O_last;

    modport master (
        output O_valid, O_idx0, O_idx1, O_idx2, O_first, O_row_end, O_last,
        input  I_ready
    );

    modport slave (
        input  O_valid, O_idx0, O_idx1, O_idx2, O_first, O_row_end, O_last,
        output I_ready
    );
endinterface

// File: rtl/cm_loop_ctrl.sv
// Three-level nested loop sequencer: walks (idx2, idx1, idx0) with idx0 fastest,
// one tuple per accepted beat, with start/abort/done control.
module cm_loop_ctrl #(
    parameter int C_WIDTH = 8
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_start,
    input  logic               I_abort,
    input  logic [C_WIDTH-1:0] I_upper0,
    input  logic [C_WIDTH-1:0] I_upper1,
    input  logic [C_WIDTH-1:0] I_upper2,
    output logic               O_busy,
    output logic               O_done,
    cm_loop_ctrl_if.master     bus
);
    localparam logic [C_WIDTH-1:0] ONE  = C_WIDTH'(1);
    localparam logic [C_WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [C_WIDTH-1:0] max0, max1, max2;
    logic [C_WIDTH-1:0] idx0, idx1, idx2;
    logic               valid_r, first_r, row_end_r, last_r, busy_r, done_r;

    logic               wrap0, wrap1;
    logic [C_WIDTH-1:0] nxt0, nxt1, nxt2;
    logic               nxt_row_end, nxt_last;
    logic               any_zero;

    // Next tuple and its position flags, so the flags leave the register
    // already aligned with the indices they describe.
    always_comb begin
        wrap0       = (idx0 == max0);
        wrap1       = (idx1 == max1);
        nxt0        = wrap0 ? ZERO : idx0 + ONE;
        nxt1        = idx1;
        nxt2        = idx2;
        if (wrap0) begin
            nxt1 = wrap1 ? ZERO : idx1 + ONE;
            if (wrap1) begin
                nxt2 = idx2 + ONE;
            end
        end
        nxt_row_end = (nxt0 == max0);
        nxt_last    = (nxt0 == max0) && (nxt1 == max1) && (nxt2 == max2);
        any_zero    = (I_upper0 == ZERO) || (I_upper1 == ZERO) || (I_upper2 == ZERO);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state     <= ST_IDLE;
            max0      <= '0;
            max1      <= '0;
            max2      <= '0;
            idx0      <= '0;
            idx1      <= '0;
            idx2      <= '0;
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            row_end_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (I_abort) begin
            state     <= ST_IDLE;
            idx0      <= '0;
            idx1      <= '0;
            idx2      <= '0;
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            row_end_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (I_start) begin
                        max0   <= I_upper0 - ONE;
                        max1   <= I_upper1 - ONE;
                        max2   <= I_upper2 - ONE;
                        idx0   <= '0;
                        idx1   <= '0;
                        idx2   <= '0;
                        busy_r <= 1'b1;
                        if (any_zero) begin
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            valid_r   <= 1'b1;
                            first_r   <= 1'b1;
                            row_end_r <= (I_upper0 == ONE);
                            last_r    <= (I_upper0 == ONE) && (I_upper1 == ONE) && (I_upper2 == ONE);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.I_ready) begin
                        if (last_r) begin
                            state     <= ST_DONE;
                            valid_r   <= 1'b0;
                            first_r   <= 1'b0;
                            row_end_r <= 1'b0;
                            last_r    <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            idx0      <= nxt0;
                            idx1      <= nxt1;
                            idx2      <= nxt2;
                            first_r   <= 1'b0;
                            row_end_r <= nxt_row_end;
                            last_r    <= nxt_last;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_valid   = valid_r;
    assign bus.O_idx0    = idx0;
    assign bus.O_idx1    = idx1;
    assign bus.O_idx2    = idx2;
    assign bus.O_first   = first_r;
    assign bus.O_row_end = row_end_r;
    assign bus.O_last    = last_r;
    assign O_busy        = busy_r;
    assign O_done        = done_r;
endmodule

// File: doc/cm_loop_ctrl.md
# cm_loop_ctrl

Three-level nested loop sequencer for the cnna datapath. On a start pulse it latches three loop bounds and emits every index tuple (idx2, idx1, idx0), innermost idx0 fastest, over a valid/ready handshake. The tuples drive ibuf read addressing and the main process compute loops. It replaces hand-chained counters with a single controller that has start, done, abort and stall semantics.

## Interface
- C_WIDTH, 8, width of each bound and index; legal bounds 0..2^C_WIDTH-1
- I_clk  input  1  clock, all logic rising-edge
- I_rst_n  input  1  asynchronous, active-low reset
- I_start  input  1  start pulse; sampled only in IDLE
- I_abort  input  1  synchronous abort; returns to IDLE, no O_done
- I_upper0  input  C_WIDTH  innermost loop bound (count of idx0 values)
- I_upper1  input  C_WIDTH  middle loop bound
- I_upper2  input  C_WIDTH  outermost loop bound
- I_ready  input  1  downstream accepts current tuple
- O_valid  output  1  current tuple valid
- O_idx0 / O_idx1 / O_idx2  output  C_WIDTH each  current indices
- O_first  output  1  high on the (0,0,0) beat while O_valid
- O_row_end  output  1  high while O_valid and idx0 == upper0-1
- O_last  output  1  high on the final tuple while O_valid
- O_busy  output  1  high in RUN and DONE
- O_done  output  1  one-cycle pulse at completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on I_start, latch I_upper0/1/2 into internal registers and clear all indices.
  - If any bound is 0, go to DONE.
  - Otherwise go to RUN.
- RUN: O_valid=1. A beat completes on O_valid && I_ready.
- On each beat the indices advance as follows:
  - idx0 increments.
  - When idx0 == upper0-1, idx0 wraps to 0 and idx1 increments.
  - When idx1 also wraps (idx1 == upper1-1), idx2 increments.
  - When the beat is the final tuple (all three at upper-1), go to DONE; indices hold.
- I_ready low: all indices and flags hold; O_valid stays 1 (no bubble or drop).
- DONE: O_done=1 for exactly one cycle, then IDLE. O_valid=0 in DONE.
- I_start outside IDLE is ignored. Bound inputs are ignored after latching, so changing them mid-run has no effect.
- I_abort in any state: next state is IDLE, indices cleared, O_valid=0, no O_done. I_abort has priority over I_start and I_ready.
- Arithmetic: compare against latched upper minus 1 at C_WIDTH bits. Wrap-compare flags may be pre-registered, provided they are correct on the first beat and on back-to-back beats. Total beats = upper0*upper1*upper2.
- Bound 1 on a level: that index stays 0 and wraps every beat.

## Timing
- Reset (I_rst_n low, asynchronous): state IDLE; O_valid, O_first, O_row_end, O_last, O_busy, O_done = 0; O_idx0/1/2 = 0.
- Start latency: I_start high at edge N makes O_valid=1 with (0,0,0) and O_busy=1 from edge N+1.
- Throughput: one tuple per cycle with I_ready held high.
- Completion: final beat accepted at edge M gives O_valid=0 and O_done=1 in cycle M+1. IDLE (O_busy=0) from M+2; the earliest accepted next I_start is at M+2.
- Zero bound: I_start at edge N gives O_done at N+1, O_valid never asserts.
- O_first, O_row_end and O_last are qualified by O_valid and change only on an accepted beat, a start, or an abort.
- Reset asserted mid-RUN aborts immediately with no O_done. After release the block needs a new I_start.

## Test plan
- Bounds (2,2,2), I_ready=1:
  - eight beats, idx2,idx1,idx0 = 000,001,010,011,100,101,110,111;
  - O_first on beat 0; O_row_end on beats 1,3,5,7; O_last on beat 7;
  - O_done one cycle after beat 7.
- Bounds (3,1,2) with I_ready toggling 1,0,0,1,...:
  - six beats total; tuple held stable while I_ready=0;
  - no duplicate or skipped tuple.
- Bound upper1=0: O_valid never high; O_done exactly one cycle after I_start; O_busy high for that one cycle.
- Bounds (1,1,1):
  - single beat with O_first=O_row_end=O_last=1;
  - I_start pulsed during RUN/DONE is ignored, and a second start after IDLE produces a fresh beat.
- Bounds (4,4,4), I_abort at beat 10: O_valid=0 next cycle, indices 0, no O_done; a following I_start restarts at (0,0,0).
- Bounds (255,255,1) at C_WIDTH=8:
  - idx0 wraps from 254 to 0 with no overflow; 65025 beats total;
  - I_rst_n pulsed low mid-run drives all outputs to 0 asynchronously.
